// File: rtl/wb_writer_pkg.sv
// Shared constants for the writeback path: datapath width, register count,
// register address width and the encoding of the arbiter's last-grant bit.
package riscv_pkg;
  localparam int   XLEN       = 32;
  localparam int   NREG       = 32;
  localparam int   REG_ADDR_W = 5;

  // Encoding of last_grant: which producer won the most recent transfer.
  localparam logic GNT_ALU = 1'b0;
  localparam logic GNT_MEM = 1'b1;
endpackage

// File: rtl/wb_writer_if.sv
// Bus bundle for wb_writer: the two producer valid/ready ports, the decode
// issue port, the busy scoreboard and the register-file write port.
// slave  : view used by wb_writer.
// master : view used by the producers / decode / register file side (bench).
interface wb_writer_if
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int NREG = riscv_pkg::NREG
);
  localparam int AW = $clog2(NREG);

  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [NREG-1:0] busy;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wrdata;
  logic            wr_en;
  logic [31:0]     wb_count;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  issue_valid, issue_rd,
    output alu_ready, mem_ready, busy, wr_addr, wrdata, wr_en, wb_count
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output issue_valid, issue_rd,
    input  alu_ready, mem_ready, busy, wr_addr, wrdata, wr_en, wb_count
  );
endinterface

// File: rtl/wb_writer_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter (ALU vs MEM).
// Ports:
//   clk, nrst          : clock, async active-low reset
//   i_req_alu/i_req_mem: request (producer valid)
//   o_gnt_alu/o_gnt_mem: combinational one-hot-or-zero grant
// A grant is a transfer (the grant is the producer's ready), so the
// last-grant bit advances on every grant.
module rr_arb2
  import riscv_pkg::*;
(
  input  logic clk,
  input  logic nrst,
  input  logic i_req_alu,
  input  logic i_req_mem,
  output logic o_gnt_alu,
  output logic o_gnt_mem
);
  logic r_last_grant;

  // On contention the port that did not win last time gets it.
  assign o_gnt_alu = i_req_alu & (~i_req_mem | (r_last_grant == GNT_MEM));
  assign o_gnt_mem = i_req_mem & (~i_req_alu | (r_last_grant == GNT_ALU));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)          r_last_grant <= GNT_ALU;
    else if (o_gnt_alu) r_last_grant <= GNT_ALU;
    else if (o_gnt_mem) r_last_grant <= GNT_MEM;
  end
endmodule

// File: rtl/wb_writer.sv
// wb_writer: writeback driver for the register file's single write port.
// Ports:
//   clk, nrst : clock, async active-low reset
//   bus       : wb_writer_if.slave -- ALU/MEM valid/ready result ports,
//               decode issue port, busy scoreboard, register-file write
//               port (wr_addr/wrdata/wr_en) and committed-write counter.
// Results are arbitrated round-robin, registered into the write port, and
// the busy bit of the destination drops on the edge the file captures it.
module wb_writer
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int NREG = riscv_pkg::NREG
)(
  input  logic        clk,
  input  logic        nrst,
  wb_writer_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  logic            w_gnt_alu, w_gnt_mem, w_xfer;
  logic [AW-1:0]   w_rd;
  logic [XLEN-1:0] w_data;
  logic [NREG-1:0] w_busy_nxt;

  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [XLEN-1:0] r_wrdata;
  logic [NREG-1:0] r_busy;
  logic [31:0]     r_wb_count;

  rr_arb2 u_arb (
    .clk       (clk),
    .nrst      (nrst),
    .i_req_alu (bus.alu_valid),
    .i_req_mem (bus.mem_valid),
    .o_gnt_alu (w_gnt_alu),
    .o_gnt_mem (w_gnt_mem)
  );

  assign bus.alu_ready = w_gnt_alu;
  assign bus.mem_ready = w_gnt_mem;
  assign w_xfer        = w_gnt_alu | w_gnt_mem;
  assign w_rd          = w_gnt_mem ? bus.mem_rd   : bus.alu_rd;
  assign w_data        = w_gnt_mem ? bus.mem_data : bus.alu_data;

  // Clear for the write leaving now, then set for the new issue so that a
  // newer outstanding producer of the same register keeps it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wr_en) w_busy_nxt[r_wr_addr] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != '0)) w_busy_nxt[bus.issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wrdata   <= '0;
      r_busy     <= '0;
      r_wb_count <= '0;
    end else begin
      // x0 transfers are consumed here with no write pulse.
      r_wr_en <= w_xfer && (w_rd != '0);
      if (w_xfer && (w_rd != '0)) begin
        r_wr_addr <= w_rd;
        r_wrdata  <= w_data;
      end
      r_busy <= w_busy_nxt;
      if (r_wr_en) r_wb_count <= r_wb_count + 32'd1;
    end
  end

  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wrdata   = r_wrdata;
  assign bus.busy     = r_busy;
  assign bus.wb_count = r_wb_count;
endmodule

// File: tb/tb_wb_writer.sv
module tb_wb_writer;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_writer_if bus ();

  wb_writer dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.issue_valid = 0; bus.issue_rd = '0;

    // Reset then idle
    nxt(); nxt();
    nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nxt();
      chk("idle_wr_en", {31'd0, bus.wr_en}, 32'd0);
      chk("idle_busy", bus.busy, 32'd0);
      chk("idle_count", bus.wb_count, 32'd0);
      chk("idle_rdy", {30'd0, bus.alu_ready, bus.mem_ready}, 32'd0);
    end

    // Single ALU write
    bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    #1;
    chk("alu_ready", {31'd0, bus.alu_ready}, 32'd1);
    chk("mem_ready_idle", {31'd0, bus.mem_ready}, 32'd0);
    nxt();
    bus.alu_valid = 0;
    chk("single_wr_en", {31'd0, bus.wr_en}, 32'd1);
    chk("single_addr", {27'd0, bus.wr_addr}, 32'd5);
    chk("single_data", bus.wrdata, 32'hDEADBEEF);
    nxt();
    chk("single_wr_en_off", {31'd0, bus.wr_en}, 32'd0);
    chk("single_count", bus.wb_count, 32'd1);
    chk("single_hold_addr", {27'd0, bus.wr_addr}, 32'd5);

    // x0 discard: accepted, no write, no count; last_grant becomes MEM
    bus.mem_valid = 1; bus.mem_rd = 5'd0; bus.mem_data = 32'h1234;
    #1;
    chk("x0_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
    nxt();
    bus.mem_valid = 0;
    chk("x0_wr_en", {31'd0, bus.wr_en}, 32'd0);
    nxt();
    chk("x0_wr_en2", {31'd0, bus.wr_en}, 32'd0);
    chk("x0_count", bus.wb_count, 32'd1);
    chk("x0_addr_hold", {27'd0, bus.wr_addr}, 32'd5);

    // Contention: ALU first after the MEM x0 grant, then alternate
    bus.alu_valid = 1; bus.alu_rd = 5'd1; bus.alu_data = 32'hA1;
    bus.mem_valid = 1; bus.mem_rd = 5'd11; bus.mem_data = 32'hB11;
    #1;
    chk("c0_alu_rdy", {31'd0, bus.alu_ready}, 32'd1);
    chk("c0_mem_rdy", {31'd0, bus.mem_ready}, 32'd0);
    nxt();
    bus.alu_rd = 5'd2; bus.alu_data = 32'hA2;
    #1;
    chk("c1_addr", {27'd0, bus.wr_addr}, 32'd1);
    chk("c1_data", bus.wrdata, 32'hA1);
    chk("c1_mem_rdy", {31'd0, bus.mem_ready}, 32'd1);
    chk("c1_alu_rdy", {31'd0, bus.alu_ready}, 32'd0);
    nxt();
    bus.mem_rd = 5'd12; bus.mem_data = 32'hB12;
    #1;
    chk("c2_addr", {27'd0, bus.wr_addr}, 32'd11);
    chk("c2_data", bus.wrdata, 32'hB11);
    chk("c2_alu_rdy", {31'd0, bus.alu_ready}, 32'd1);
    nxt();
    bus.alu_rd = 5'd3; bus.alu_data = 32'hA3;
    #1;
    chk("c3_addr", {27'd0, bus.wr_addr}, 32'd2);
    chk("c3_mem_rdy", {31'd0, bus.mem_ready}, 32'd1);
    nxt();
    bus.alu_valid = 0; bus.mem_valid = 0;
    chk("c4_addr", {27'd0, bus.wr_addr}, 32'd12);
    chk("c4_data", bus.wrdata, 32'hB12);
    chk("c4_wr_en", {31'd0, bus.wr_en}, 32'd1);
    chk("c4_count", bus.wb_count, 32'd4);
    nxt();
    chk("c5_wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("c5_count", bus.wb_count, 32'd5);

    // Scoreboard set/clear; x0 issue ignored
    bus.issue_valid = 1; bus.issue_rd = 5'd7;
    nxt();
    bus.issue_rd = 5'd0;
    chk("sb_set7", bus.busy, 32'h0000_0080);
    bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
    nxt();
    bus.issue_valid = 0; bus.alu_valid = 0;
    chk("sb_x0_issue", bus.busy, 32'h0000_0080);
    chk("sb_wr7", {27'd0, bus.wr_addr}, 32'd7);
    nxt();
    chk("sb_clear7", bus.busy, 32'd0);
    chk("sb_count", bus.wb_count, 32'd6);

    // Set and clear of x7 on the same edge: set wins
    bus.issue_valid = 1; bus.issue_rd = 5'd7;
    bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 32'h78;
    nxt();
    bus.alu_valid = 0;
    chk("sb2_wr_en", {31'd0, bus.wr_en}, 32'd1);
    chk("sb2_busy", bus.busy, 32'h0000_0080);
    nxt();
    bus.issue_valid = 0;
    chk("sb2_set_wins", bus.busy, 32'h0000_0080);
    chk("sb2_count", bus.wb_count, 32'd7);

    // Reset mid-flight with wr_en high to x9
    bus.alu_valid = 1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    nxt();
    bus.alu_valid = 0;
    chk("rst_pre_wr_en", {31'd0, bus.wr_en}, 32'd1);
    chk("rst_pre_addr", {27'd0, bus.wr_addr}, 32'd9);
    #2 nrst = 1'b0;
    #1;
    chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("rst_busy", bus.busy, 32'd0);
    chk("rst_count", bus.wb_count, 32'd0);
    chk("rst_addr", {27'd0, bus.wr_addr}, 32'd0);
    chk("rst_data", bus.wrdata, 32'd0);
    nxt();
    nrst = 1'b1;
    nxt();
    chk("post_rst_wr_en", {31'd0, bus.wr_en}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
